// File: rtl/plot_sink.sv
// rtl/plot_sink.sv - pixel plot queue feeding a handshaked framebuffer write port
module plot_sink #(
  parameter int DEPTH = 8,
  parameter int SCR_W = 320,
  parameter int SCR_H = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  x,
  input  logic [7:0]  y,
  input  logic [11:0] c,
  input  logic        plot,
  output logic        full,
  output logic [16:0] mem_addr,
  output logic [11:0] mem_data,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic [7:0]  drop_cnt,
  output logic [15:0] wr_cnt,
  output logic        idle
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  state_t        state_q, state_d;
  logic [28:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          on_screen, push, pop, ack_edge;
  logic [28:0]   head;
  logic [16:0]   head_addr;

  assign on_screen = ({23'd0, x} < 32'(SCR_W)) && ({24'd0, y} < 32'(SCR_H));
  // full uses the registered count, so a pop on the same edge never admits an extra push
  assign full      = (count == FULL_CNT);
  assign push      = plot && on_screen && !full;
  assign head      = fifo_mem[rd_ptr];
  assign head_addr = 17'(head[19:12]) * 17'(SCR_W) + 17'(head[28:20]);
  assign mem_we    = (state_q == REQ);
  assign ack_edge  = (state_q == REQ) && mem_ack;
  assign idle      = (count == '0) && (state_q == IDLE);

  // Next state and pop decision: load a new entry whenever the port is free or just acknowledged
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (count != '0) pop = 1'b1;
          else state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register; reset abandons any pending write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FIFO storage; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {x, y, c};
  end

  // FIFO pointers and occupancy, wrapping modulo DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Write port address/data, loaded from the FIFO head on every pop and held otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr <= '0;
      mem_data <= '0;
    end else if (pop) begin
      mem_addr <= head_addr;
      mem_data <= head[11:0];
    end
  end

  // Statistics: saturating drop counter and wrapping completed-write counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
      wr_cnt   <= '0;
    end else begin
      if (plot && !push && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      if (ack_edge) wr_cnt <= wr_cnt + 1'b1;
    end
  end

endmodule
